// File: rtl/tuner_disp_pkg.sv
// ----------------------------------------------------------------------------
// tuner_disp_pkg
// Shared definitions for the tuner display overlay renderer: pixel/colour/
// address widths, screen dimensions, marker colours, the renderer state
// encoding and the pitch-to-colour helper.
// ----------------------------------------------------------------------------
package tuner_disp_pkg;

    localparam int X_W    = 8;   // screen x coordinate
    localparam int Y_W    = 7;   // screen y coordinate
    localparam int C_W    = 9;   // 3:3:3 colour
    localparam int A_W    = 15;  // background ROM address
    localparam int NOTE_W = 6;   // note code

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H     = 120;

    localparam logic [C_W-1:0] C_LOW   = 9'h1C9;
    localparam logic [C_W-1:0] C_HIGH  = 9'h055;
    localparam logic [C_W-1:0] C_TUNED = 9'h0AA;
    localparam logic [C_W-1:0] C_WHITE = 9'h1FF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_STR,
        ST_BG_RD,
        ST_CUR_ERASE,
        ST_CUR_DRAW,
        ST_DONE
    } state_t;

    // pitch code: 00 low, 11 high, 10 in tune, 01 undefined (shown white)
    function automatic logic [C_W-1:0] pitch_colour(input logic [1:0] pitch);
        logic [C_W-1:0] c;
        case (pitch)
            2'b00:   c = C_LOW;
            2'b11:   c = C_HIGH;
            2'b10:   c = C_TUNED;
            default: c = C_WHITE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tuner_overlay_renderer_if.sv
// ----------------------------------------------------------------------------
// tuner_overlay_renderer_if
// Bundles the renderer's source-side inputs (frame tick, note/pitch, cursor),
// the background ROM port and the pixel-write port towards vga_adapter.
//   slave  : the renderer (consumes tick/note/cursor/bg_q, drives plot/bg_addr)
//   master : the surrounding system / testbench
// ----------------------------------------------------------------------------
interface tuner_overlay_renderer_if import tuner_disp_pkg::*; ();

    logic              tick;
    logic              note_valid;
    logic [NOTE_W-1:0] note_num;
    logic [1:0]        pitch;
    logic              cursor_en;
    logic [X_W-1:0]    cursor_x;
    logic [Y_W-1:0]    cursor_y;
    logic [A_W-1:0]    bg_addr;
    logic [C_W-1:0]    bg_q;
    logic              plot;
    logic [X_W-1:0]    plot_x;
    logic [Y_W-1:0]    plot_y;
    logic [C_W-1:0]    plot_c;
    logic              busy;
    logic              frame_done;

    modport slave (
        input  tick, note_valid, note_num, pitch, cursor_en, cursor_x, cursor_y, bg_q,
        output bg_addr, plot, plot_x, plot_y, plot_c, busy, frame_done
    );

    modport master (
        output tick, note_valid, note_num, pitch, cursor_en, cursor_x, cursor_y, bg_q,
        input  bg_addr, plot, plot_x, plot_y, plot_c, busy, frame_done
    );

endinterface

// File: rtl/string_colour_map.sv
// ----------------------------------------------------------------------------
// string_colour_map
// Combinational target colour of one string marker. The marker takes the
// pitch colour when the detected note is this string's note, else white.
// Ports:
//   i_note_valid  note_num/pitch meaningful
//   i_note_num    detected note code
//   i_pitch       pitch code
//   i_str_note    note code assigned to this string
//   o_colour      target marker colour
// ----------------------------------------------------------------------------
module string_colour_map
    import tuner_disp_pkg::*;
(
    input  logic              i_note_valid,
    input  logic [NOTE_W-1:0] i_note_num,
    input  logic [1:0]        i_pitch,
    input  logic [NOTE_W-1:0] i_str_note,
    output logic [C_W-1:0]    o_colour
);

    logic w_match;

    assign w_match  = i_note_valid && (i_note_num == i_str_note);
    assign o_colour = w_match ? pitch_colour(i_pitch) : C_WHITE;

endmodule

// File: rtl/tuner_overlay_renderer.sv
// ----------------------------------------------------------------------------
// tuner_overlay_renderer
// Per-frame pixel-write engine for the tuner display. On a frame tick it
// redraws only the string markers whose colour changed, restores the
// background under the previous cursor and draws the new cursor, issuing at
// most one registered pixel write per cycle.
// Ports:
//   clock   single clock domain
//   resetn  asynchronous active-low reset; aborts a frame in progress
//   bus     tuner_overlay_renderer_if.slave (tick/note/cursor in, bg ROM,
//           plot/plot_x/plot_y/plot_c, busy, frame_done out)
//
// state        | meaning
// -------------+------------------------------------------------------------
// ST_IDLE      | waiting for tick; snapshot of targets and cursor on tick
// ST_SCAN      | test string i for dirty, one cycle per string
// ST_STR       | draw pixel k of string i's marker
// ST_BG_RD     | background address of previous cursor is on bg_addr
// ST_CUR_ERASE | write bg_q at the previous cursor position
// ST_CUR_DRAW  | draw new cursor (if enabled), record it as previous cursor
// ST_DONE      | frame complete, frame_done follows
// ----------------------------------------------------------------------------
module tuner_overlay_renderer
    import tuner_disp_pkg::*;
#(
    parameter int                        NUM_STR  = 4,
    parameter logic [NUM_STR*X_W-1:0]    STR_X    = {8'd67, 8'd76, 8'd73, 8'd70},
    parameter logic [NUM_STR*NOTE_W-1:0] STR_NOTE = {6'd32, 6'd29, 6'd25, 6'd22},
    parameter int                        STR_Y0   = 16,
    parameter int                        STR_LEN  = 49,
    parameter int                        SCREEN_W = SCREEN_W_DEF,
    parameter logic [C_W-1:0]            CUR_C    = 9'h1F0
)(
    input  logic                     clock,
    input  logic                     resetn,
    tuner_overlay_renderer_if.slave  bus
);

    localparam int IW = (NUM_STR > 1) ? $clog2(NUM_STR) : 1;
    localparam int KW = 6;
    localparam logic [IW-1:0] I_LAST = IW'(NUM_STR - 1);
    localparam logic [KW-1:0] K_LAST = KW'(STR_LEN - 1);

    // ------------------------------------------------------------------
    // Per-string constants and live target colours
    // ------------------------------------------------------------------
    logic [X_W-1:0] w_str_x [NUM_STR];
    logic [C_W-1:0] w_tgt   [NUM_STR];

    for (genvar g = 0; g < NUM_STR; g++) begin : g_str
        assign w_str_x[g] = STR_X[g*X_W +: X_W];

        string_colour_map u_colour_map (
            .i_note_valid (bus.note_valid),
            .i_note_num   (bus.note_num),
            .i_pitch      (bus.pitch),
            .i_str_note   (STR_NOTE[g*NOTE_W +: NOTE_W]),
            .o_colour     (w_tgt[g])
        );
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t         r_state;
    logic [IW-1:0]  r_i;
    logic [KW-1:0]  r_k;
    logic [C_W-1:0] r_tgt   [NUM_STR];  // targets frozen at tick
    logic [C_W-1:0] r_shown [NUM_STR];  // colour currently on screen
    logic           r_cur_en;
    logic [X_W-1:0] r_cur_x;
    logic [Y_W-1:0] r_cur_y;
    logic [X_W-1:0] r_past_x;
    logic [Y_W-1:0] r_past_y;
    logic           r_have_cur;

    logic           r_plot;
    logic [X_W-1:0] r_plot_x;
    logic [Y_W-1:0] r_plot_y;
    logic [C_W-1:0] r_plot_c;
    logic [A_W-1:0] r_bg_addr;
    logic           r_busy;
    logic           r_frame_done;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    state_t         w_state_nxt;
    state_t         w_after_scan;
    logic           w_dirty;
    logic           w_i_last;
    logic           w_k_last;
    logic [A_W-1:0] w_bg_addr;

    logic           w_plot;
    logic [X_W-1:0] w_px;
    logic [Y_W-1:0] w_py;
    logic [C_W-1:0] w_pc;
    logic           w_done;
    logic           w_bg_load;

    assign w_dirty      = (r_tgt[r_i] != r_shown[r_i]);
    assign w_i_last     = (r_i == I_LAST);
    assign w_k_last     = (r_k == K_LAST);
    assign w_after_scan = r_have_cur ? ST_BG_RD : ST_CUR_DRAW;
    assign w_bg_addr    = A_W'(r_past_y) * A_W'(SCREEN_W) + A_W'(r_past_x);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.tick) w_state_nxt = ST_SCAN;
            end
            ST_SCAN: begin
                if (w_dirty)       w_state_nxt = ST_STR;
                else if (w_i_last) w_state_nxt = w_after_scan;
            end
            ST_STR: begin
                // the last string leaves directly, so SCAN runs once per string
                if (w_k_last) w_state_nxt = w_i_last ? w_after_scan : ST_SCAN;
            end
            ST_BG_RD:     w_state_nxt = ST_CUR_ERASE;
            ST_CUR_ERASE: w_state_nxt = ST_CUR_DRAW;
            ST_CUR_DRAW:  w_state_nxt = ST_DONE;
            ST_DONE:      w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (registered below)
    // ------------------------------------------------------------------
    always_comb begin
        w_plot    = 1'b0;
        w_px      = '0;
        w_py      = '0;
        w_pc      = '0;
        w_done    = 1'b0;
        // address goes out during BG_RD so the ROM answers during CUR_ERASE
        w_bg_load = (w_state_nxt == ST_BG_RD);
        case (r_state)
            ST_STR: begin
                w_plot = 1'b1;
                w_px   = w_str_x[r_i];
                w_py   = Y_W'(STR_Y0) + Y_W'(r_k);
                w_pc   = r_tgt[r_i];
            end
            ST_CUR_ERASE: begin
                w_plot = 1'b1;
                w_px   = r_past_x;
                w_py   = r_past_y;
                w_pc   = bus.bg_q;
            end
            ST_CUR_DRAW: begin
                w_plot = r_cur_en;
                w_px   = r_cur_x;
                w_py   = r_cur_y;
                w_pc   = CUR_C;
            end
            ST_DONE: w_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_plot       <= 1'b0;
            r_plot_x     <= '0;
            r_plot_y     <= '0;
            r_plot_c     <= '0;
            r_bg_addr    <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_plot       <= w_plot;
            r_frame_done <= w_done;
            r_busy       <= (w_state_nxt != ST_IDLE);
            // coordinates hold between writes
            if (w_plot) begin
                r_plot_x <= w_px;
                r_plot_y <= w_py;
                r_plot_c <= w_pc;
            end
            if (w_bg_load) r_bg_addr <= w_bg_addr;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: indices, snapshot, shown colours, cursor history
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_i        <= '0;
            r_k        <= '0;
            r_cur_en   <= 1'b0;
            r_cur_x    <= '0;
            r_cur_y    <= '0;
            r_past_x   <= '0;
            r_past_y   <= '0;
            r_have_cur <= 1'b0;
            for (int n = 0; n < NUM_STR; n++) begin
                r_tgt[n]   <= '0;
                r_shown[n] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.tick) begin
                        r_i      <= '0;
                        r_k      <= '0;
                        r_cur_en <= bus.cursor_en;
                        r_cur_x  <= bus.cursor_x;
                        r_cur_y  <= bus.cursor_y;
                        for (int n = 0; n < NUM_STR; n++) r_tgt[n] <= w_tgt[n];
                    end
                end
                ST_SCAN: begin
                    r_k <= '0;
                    if (!w_dirty && !w_i_last) r_i <= r_i + IW'(1);
                end
                ST_STR: begin
                    if (w_k_last) begin
                        r_shown[r_i] <= r_tgt[r_i];
                        r_k          <= '0;
                        if (!w_i_last) r_i <= r_i + IW'(1);
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                ST_CUR_DRAW: begin
                    if (r_cur_en) begin
                        r_past_x   <= r_cur_x;
                        r_past_y   <= r_cur_y;
                        r_have_cur <= 1'b1;
                    end else begin
                        r_have_cur <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Port drive
    // ------------------------------------------------------------------
    assign bus.plot       = r_plot;
    assign bus.plot_x     = r_plot_x;
    assign bus.plot_y     = r_plot_y;
    assign bus.plot_c     = r_plot_c;
    assign bus.bg_addr    = r_bg_addr;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;

endmodule
